sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester arbiter and access sequencer in front of the banked SRAM control unit. It accepts read/write requests from two clients over valid/ready handshakes and round-robins them onto the single memory port (CE/WE/ADDR/DIN), one access per cycle. It tracks in-flight reads through the control unit's two-cycle read pipeline and returns each word to its requester with a per-port response strobe. It sits between the system bus adapters and the memory CU/bank array.

## Interface
Parameters:
- ADDR_BIT_COUNT, 9, address width, with bank bit as MSB; passed through unchanged.
- WORD_SIZE, 32, data width.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ0_VALID / REQ1_VALID  in  1  request pending on port 0/1.
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle.
- REQ0_WE / REQ1_WE  in  1  1 = write, 0 = read.
- REQ0_ADDR / REQ1_ADDR  in  ADDR_BIT_COUNT  word address.
- REQ0_WDATA / REQ1_WDATA  in  WORD_SIZE  write data.
- RSP0_VALID / RSP1_VALID  out  1  one-cycle strobe: RSP_DATA holds read data for port 0/1.
- RSP_DATA  out  WORD_SIZE  shared read-return data.
- MEM_CE, MEM_WE  out  1  registered CU chip enable / write enable.
- MEM_ADDR  out  ADDR_BIT_COUNT  registered CU address.
- MEM_DIN  out  WORD_SIZE  registered write data to the array.
- MEM_DOUT  in  WORD_SIZE  muxed bank output from the CU.
- BUSY  out  1  any access issued or read in flight.

## Operation
- Arbitration is combinational on REQx_VALID and the round-robin pointer RR (reset 0). At most one READY is high per cycle.
  - If only one port is valid, that port is granted.
  - If both ports are valid, port RR is granted.
  - If neither port is valid, no grant is made.
- RR update, on an edge where a grant fires:
  - If both ports were valid, RR becomes the port that was not granted.
  - If only one port was valid, RR is unchanged.
- Accept = VALID & READY. The requester must hold VALID, WE, ADDR and WDATA stable until accepted. VALID is not withdrawn by the arbiter.
- Issue stage, on an accept edge:
  - MEM_CE is set to 1.
  - MEM_WE, MEM_ADDR and MEM_DIN load from the granted port.
  - Tag T1 = {rd = ~WE, port}.
  - With no accept: MEM_CE = 0 and MEM_WE = 0. MEM_ADDR and MEM_DIN hold their values. T1.rd = 0.
- Access stage: the CU samples MEM_* on the next edge. T2 <= T1.
- Return stage: on the following edge, if T2.rd is set:
  - RSP_DATA <= MEM_DOUT.
  - RSPx_VALID <= 1 for x = T2.port, else 0.
  - RSP_DATA holds its value when no read returns.
- Writes produce no response.
- Back-to-back accesses from any mix of ports are allowed. Throughput is one access per cycle.
- Read-after-write to the same address on consecutive accepts returns the new data; the array orders them by issue.
- BUSY = MEM_CE | T1.rd | T2.rd.

## Timing
- Reset (asynchronous assert; synchronous-style release on the next edge):
  - Cleared to 0: MEM_CE, MEM_WE, MEM_ADDR, MEM_DIN, RSP_DATA, RSP0_VALID, RSP1_VALID, BUSY, RR, T1, T2.
  - READY is 0 while RST is high.
- Read latency: accept at edge N, then MEM_CE = 1 in cycle N, CU sample at N+1, RSPx_VALID = 1 and RSP_DATA valid in cycle N+2 for exactly one cycle.
- Write: accept at N, array written during cycle N+1, BUSY drops after N+1 if nothing follows.
- READY is combinational from VALID (zero-cycle). No combinational path from MEM_DOUT to any output.
- Reset mid-operation: in-flight reads are discarded and no RSP strobe follows. MEM_CE drops immediately.
- Simultaneous edge cases:
  - A new accept and a read return in the same cycle are independent.
  - Both ports asserting VALID in the first cycle after reset: port 0 wins.

## Test plan
- Single read, port 0, ADDR=0x1A5 after write of 0xDEADBEEF: accept at N, RSP0_VALID=1 at N+2, RSP_DATA=0xDEADBEEF; RSP1_VALID stays 0.
- Both ports hold reads for 6 cycles: grants alternate 0,1,0,1,0,1; RSP strobes alternate ports at N+2..N+7 with correct per-address data.
- Port 1 only valid for 4 cycles with RR=1 pending: port 1 granted every cycle; RR unchanged (still 1) after.
- Write 0x12345678 to 0x040 then read 0x040 on the next cycle: read returns 0x12345678; exactly one RSP strobe.
- Bank crossing: reads to 0x0FF then 0x100 back-to-back return the DOUT0 then DOUT1 values in order.
- Assert RST one cycle after a read accept: MEM_CE=0 immediately; no RSPx_VALID in following 3 cycles; RR=0 after release.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Request, response and memory-port bundle for the two-client SRAM arbiter.
// Handshake: a request transfers on a rising edge where REQx_VALID and REQx_READY are both high;
// the requester holds VALID/WE/ADDR/WDATA stable until then, and READY never depends on the response side.
interface sram_port_arbiter_if #(
  parameter int ADDR_BIT_COUNT = 9,
  parameter int WORD_SIZE      = 32
);
  logic                      REQ0_VALID;
  logic                      REQ1_VALID;
  logic                      REQ0_READY;
  logic                      REQ1_READY;
  logic                      REQ0_WE;
  logic                      REQ1_WE;
  logic [ADDR_BIT_COUNT-1:0] REQ0_ADDR;
  logic [ADDR_BIT_COUNT-1:0] REQ1_ADDR;
  logic [WORD_SIZE-1:0]      REQ0_WDATA;
  logic [WORD_SIZE-1:0]      REQ1_WDATA;
  logic                      RSP0_VALID;
  logic                      RSP1_VALID;
  logic [WORD_SIZE-1:0]      RSP_DATA;
  logic                      MEM_CE;
  logic                      MEM_WE;
  logic [ADDR_BIT_COUNT-1:0] MEM_ADDR;
  logic [WORD_SIZE-1:0]      MEM_DIN;
  logic [WORD_SIZE-1:0]      MEM_DOUT;
  logic                      BUSY;

  modport slave (
    input  REQ0_VALID, REQ1_VALID, REQ0_WE, REQ1_WE, REQ0_ADDR, REQ1_ADDR,
           REQ0_WDATA, REQ1_WDATA, MEM_DOUT,
    output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_DATA,
           MEM_CE, MEM_WE, MEM_ADDR, MEM_DIN, BUSY
  );

  modport master (
    output REQ0_VALID, REQ1_VALID, REQ0_WE, REQ1_WE, REQ0_ADDR, REQ1_ADDR,
           REQ0_WDATA, REQ1_WDATA, MEM_DOUT,
    input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_DATA,
           MEM_CE, MEM_WE, MEM_ADDR, MEM_DIN, BUSY
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for two request ports onto one SRAM CU port, with a
// two-stage read tag pipeline that steers returning words back to their requester.
module sram_port_arbiter #(
  parameter int ADDR_BIT_COUNT = 9,
  parameter int WORD_SIZE      = 32
) (
  input logic                CLK,
  input logic                RST,
  sram_port_arbiter_if.slave bus
);

  logic                      rr_q, rr_d;
  logic                      mem_ce_q, mem_ce_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_BIT_COUNT-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0]      mem_din_q, mem_din_d;
  logic                      t1_rd_q, t1_rd_d, t1_port_q, t1_port_d;
  logic                      t2_rd_q, t2_rd_d, t2_port_q, t2_port_d;
  logic                      rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [WORD_SIZE-1:0]      rsp_data_q, rsp_data_d;
  logic                      both, gnt0, gnt1, acc;

  // Grant is purely combinational so READY answers VALID in the same cycle.
  always_comb begin
    both = bus.REQ0_VALID & bus.REQ1_VALID;
    gnt0 = ~RST & bus.REQ0_VALID & (~bus.REQ1_VALID | ~rr_q);
    gnt1 = ~RST & bus.REQ1_VALID & (~bus.REQ0_VALID | rr_q);
    acc  = gnt0 | gnt1;
  end

  always_comb begin
    rr_d       = rr_q;
    mem_ce_d   = acc;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    t1_rd_d    = 1'b0;
    t1_port_d  = t1_port_q;
    // Pointer only moves under contention, toward the loser.
    if (acc && both) rr_d = gnt0;
    if (gnt0) begin
      mem_we_d   = bus.REQ0_WE;
      mem_addr_d = bus.REQ0_ADDR;
      mem_din_d  = bus.REQ0_WDATA;
      t1_rd_d    = ~bus.REQ0_WE;
      t1_port_d  = 1'b0;
    end else if (gnt1) begin
      mem_we_d   = bus.REQ1_WE;
      mem_addr_d = bus.REQ1_ADDR;
      mem_din_d  = bus.REQ1_WDATA;
      t1_rd_d    = ~bus.REQ1_WE;
      t1_port_d  = 1'b1;
    end
    t2_rd_d    = t1_rd_q;
    t2_port_d  = t1_port_q;
    rsp0_d     = t2_rd_q & ~t2_port_q;
    rsp1_d     = t2_rd_q & t2_port_q;
    rsp_data_d = t2_rd_q ? bus.MEM_DOUT : rsp_data_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_q       <= 1'b0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      t1_rd_q    <= 1'b0;
      t1_port_q  <= 1'b0;
      t2_rd_q    <= 1'b0;
      t2_port_q  <= 1'b0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rr_q       <= rr_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      t1_rd_q    <= t1_rd_d;
      t1_port_q  <= t1_port_d;
      t2_rd_q    <= t2_rd_d;
      t2_port_q  <= t2_port_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;
  assign bus.MEM_CE     = mem_ce_q;
  assign bus.MEM_WE     = mem_we_q;
  assign bus.MEM_ADDR   = mem_addr_q;
  assign bus.MEM_DIN    = mem_din_q;
  assign bus.RSP0_VALID = rsp0_q;
  assign bus.RSP1_VALID = rsp1_q;
  assign bus.RSP_DATA   = rsp_data_q;
  assign bus.BUSY       = mem_ce_q | t1_rd_q | t2_rd_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural CU/array model, reference memory and
// a response scoreboard keyed by {return cycle, port, data}.
module tb_sram_port_arbiter;
  localparam int A  = 9;
  localparam int W  = 32;
  localparam int QW = 16 + 1 + W;

  logic          CLK = 1'b0;
  logic          RST;
  int            checks   = 0;
  int            failures = 0;
  logic [15:0]   cyc = '0;
  logic [QW-1:0] exp_q[$];
  logic [W-1:0]  sram [512];
  logic [W-1:0]  ref_mem [512];
  logic [W-1:0]  dout_q;
  logic          rr_m;

  sram_port_arbiter_if #(.ADDR_BIT_COUNT(A), .WORD_SIZE(W)) bus();

  sram_port_arbiter #(.ADDR_BIT_COUNT(A), .WORD_SIZE(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // CU + bank array: samples the registered port on the edge after issue.
  initial begin
    for (int i = 0; i < 512; i++) sram[i] <= 32'hA5000000 ^ (i * 32'h00010203);
    dout_q <= '0;
  end
  always @(posedge CLK) begin
    cyc <= cyc + 16'd1;
    if (bus.MEM_CE) begin
      if (bus.MEM_WE) sram[bus.MEM_ADDR] <= bus.MEM_DIN;
      else            dout_q <= sram[bus.MEM_ADDR];
    end
  end
  assign bus.MEM_DOUT = dout_q;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic note_accept(input logic port, input logic we, input logic [A-1:0] addr,
                             input logic [W-1:0] data);
    if (we) ref_mem[addr] = data;
    else    exp_q.push_back({cyc + 16'd3, port, ref_mem[addr]});
  endtask

  // One clock cycle: drive, score responses, sample READY, advance to posedge+1.
  task automatic step(input logic v0, input logic we0, input logic [A-1:0] a0, input logic [W-1:0] d0,
                      input logic v1, input logic we1, input logic [A-1:0] a1, input logic [W-1:0] d1,
                      output logic r0, output logic r1);
    logic          strobe;
    logic [QW-1:0] got, e;
    bus.REQ0_VALID = v0; bus.REQ0_WE = we0; bus.REQ0_ADDR = a0; bus.REQ0_WDATA = d0;
    bus.REQ1_VALID = v1; bus.REQ1_WE = we1; bus.REQ1_ADDR = a1; bus.REQ1_WDATA = d1;
    #3;
    strobe = bus.RSP0_VALID | bus.RSP1_VALID;
    if (strobe || (exp_q.size() > 0 && exp_q[0][QW-1 -: 16] == cyc)) begin
      checks++;
      got = {cyc, bus.RSP1_VALID, bus.RSP_DATA};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected cyc=%0d rsp0=%b rsp1=%b data=%h", cyc, bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP_DATA);
      end else begin
        e = exp_q.pop_front();
        if (!strobe || (bus.RSP0_VALID && bus.RSP1_VALID) || got !== e) begin
          failures++;
          $display("FAIL rsp_scoreboard strobe=%b rsp0=%b got={cyc %0d port %b data %h} exp={cyc %0d port %b data %h}",
                   strobe, bus.RSP0_VALID, got[QW-1 -: 16], got[W], got[W-1:0], e[QW-1 -: 16], e[W], e[W-1:0]);
        end
      end
    end
    r0 = bus.REQ0_READY;
    r1 = bus.REQ1_READY;
    if (r0) note_accept(1'b0, we0, a0, d0);
    if (r1) note_accept(1'b1, we1, a1, d1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    logic r0, r1;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
  endtask

  task automatic do_reset();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    RST = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    rr_m = 1'b0;
  endtask

  task automatic test_reset();
    logic r0, r1;
    RST = 1'b1;
    bus.REQ0_VALID = 1'b1; bus.REQ0_WE = 1'b0; bus.REQ0_ADDR = 9'h011; bus.REQ0_WDATA = '0;
    bus.REQ1_VALID = 1'b1; bus.REQ1_WE = 1'b0; bus.REQ1_ADDR = 9'h122; bus.REQ1_WDATA = '0;
    @(posedge CLK);
    #1;
    checks++;
    if ({bus.REQ0_READY, bus.REQ1_READY} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {bus.REQ0_READY, bus.REQ1_READY});
    end
    checks++;
    if ({bus.MEM_CE, bus.MEM_WE, bus.RSP0_VALID, bus.RSP1_VALID, bus.BUSY} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.MEM_CE, bus.MEM_WE, bus.RSP0_VALID, bus.RSP1_VALID, bus.BUSY});
    end
    checks++;
    if (bus.MEM_ADDR !== '0 || bus.MEM_DIN !== '0 || bus.RSP_DATA !== '0) begin
      failures++; $display("FAIL reset_data addr=%h din=%h rsp=%h exp=0", bus.MEM_ADDR, bus.MEM_DIN, bus.RSP_DATA);
    end
    RST = 1'b0;
    exp_q.delete();
    rr_m = 1'b0;
    // First cycle out of reset with both ports valid: port 0 must win.
    step(1, 0, 9'h011, '0, 1, 0, 9'h122, '0, r0, r1);
    checks++;
    if ({r0, r1} !== 2'b10) begin
      failures++; $display("FAIL first_grant got=%b exp=10", {r0, r1});
    end
    idle(4);
  endtask

  task automatic test_single_read();
    logic r0, r1;
    step(1, 1, 9'h1A5, 32'hDEADBEEF, 0, 0, '0, '0, r0, r1);
    step(1, 0, 9'h1A5, 32'h0, 0, 0, '0, '0, r0, r1);
    checks++;
    if (r0 !== 1'b1 || bus.MEM_CE !== 1'b1 || bus.MEM_WE !== 1'b0 || bus.MEM_ADDR !== 9'h1A5) begin
      failures++; $display("FAIL single_issue r0=%b ce=%b we=%b addr=%h exp 1 1 0 1a5", r0, bus.MEM_CE, bus.MEM_WE, bus.MEM_ADDR);
    end
    step(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
    checks++;
    if (bus.RSP0_VALID !== 1'b0) begin
      failures++; $display("FAIL single_early got=%b exp=0", bus.RSP0_VALID);
    end
    step(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
    checks++;
    if (bus.RSP0_VALID !== 1'b1 || bus.RSP1_VALID !== 1'b0 || bus.RSP_DATA !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_return rsp0=%b rsp1=%b data=%h exp 1 0 deadbeef", bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP_DATA);
    end
    idle(3);
  endtask

  task automatic test_write_busy();
    logic r0, r1;
    step(0, 0, '0, '0, 1, 1, 9'h0C3, 32'hCAFE0001, r0, r1);
    checks++;
    if (bus.MEM_CE !== 1'b1 || bus.MEM_WE !== 1'b1 || bus.MEM_ADDR !== 9'h0C3 ||
        bus.MEM_DIN !== 32'hCAFE0001 || bus.BUSY !== 1'b1) begin
      failures++; $display("FAIL write_issue ce=%b we=%b addr=%h din=%h busy=%b", bus.MEM_CE, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN, bus.BUSY);
    end
    step(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
    checks++;
    if (bus.MEM_CE !== 1'b0 || bus.MEM_WE !== 1'b0 || bus.BUSY !== 1'b0 || bus.MEM_ADDR !== 9'h0C3) begin
      failures++; $display("FAIL write_idle ce=%b we=%b busy=%b addr=%h exp 0 0 0 0c3", bus.MEM_CE, bus.MEM_WE, bus.BUSY, bus.MEM_ADDR);
    end
    idle(2);
  endtask

  task automatic test_alternate();
    logic r0, r1;
    int   n0, n1;
    n0 = 0; n1 = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 9'h010 + 9'(n0), '0, 1, 0, 9'h150 + 9'(n1), '0, r0, r1);
      checks++;
      if (r0 !== ~rr_m || r1 !== rr_m) begin
        failures++; $display("FAIL alternate_grant i=%0d got=%b%b exp_port=%b", i, r0, r1, rr_m);
      end
      if (rr_m) n1++; else n0++;
      rr_m = ~rr_m;
    end
    idle(4);
  endtask

  task automatic test_port1_only();
    logic r0, r1;
    do_reset();
    step(1, 0, 9'h020, '0, 1, 0, 9'h120, '0, r0, r1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, '0, 1, 0, 9'h121 + 9'(i), '0, r0, r1);
      checks++;
      if ({r0, r1} !== 2'b01) begin
        failures++; $display("FAIL port1_only i=%0d got=%b exp=01", i, {r0, r1});
      end
    end
    // Pointer still favours port 1 under contention.
    step(1, 0, 9'h021, '0, 1, 0, 9'h130, '0, r0, r1);
    checks++;
    if ({r0, r1} !== 2'b01) begin
      failures++; $display("FAIL rr_held got=%b exp=01", {r0, r1});
    end
    step(1, 0, 9'h021, '0, 0, 0, '0, '0, r0, r1);
    idle(4);
  endtask

  task automatic test_raw();
    logic r0, r1;
    int   strobes;
    strobes = 0;
    step(0, 0, '0, '0, 1, 1, 9'h040, 32'h12345678, r0, r1);
    step(1, 0, 9'h040, '0, 0, 0, '0, '0, r0, r1);
    for (int i = 0; i < 4; i++) begin
      if (bus.RSP0_VALID || bus.RSP1_VALID) strobes++;
      if (bus.RSP0_VALID && bus.RSP_DATA !== 32'h12345678) begin
        checks++; failures++; $display("FAIL raw_data got=%h exp=12345678", bus.RSP_DATA);
      end
      step(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
    end
    checks++;
    if (strobes != 1) begin
      failures++; $display("FAIL raw_strobe_count got=%0d exp=1", strobes);
    end
  endtask

  task automatic test_bank_cross();
    logic r0, r1;
    step(1, 1, 9'h0FF, $urandom, 0, 0, '0, '0, r0, r1);
    step(0, 0, '0, '0, 1, 1, 9'h100, $urandom, r0, r1);
    step(1, 0, 9'h0FF, '0, 0, 0, '0, '0, r0, r1);
    step(1, 0, 9'h100, '0, 0, 0, '0, '0, r0, r1);
    idle(4);
  endtask

  task automatic test_random();
    logic          p0, p1, w0, w1, r0, r1, e0, e1;
    logic [A-1:0]  a0, a1;
    logic [W-1:0]  d0, d1;
    p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; w0 = 1'($urandom_range(0, 1)); d0 = $urandom;
        a0 = 9'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 9'h100 : 9'h000);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1; w1 = 1'($urandom_range(0, 1)); d1 = $urandom;
        a1 = 9'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 9'h100 : 9'h000);
      end
      e0 = p0 & (~p1 | ~rr_m);
      e1 = p1 & (~p0 | rr_m);
      step(p0, w0, a0, d0, p1, w1, a1, d1, r0, r1);
      checks++;
      if (r0 !== e0 || r1 !== e1) begin
        failures++; $display("FAIL random_grant i=%0d got=%b%b exp=%b%b", i, r0, r1, e0, e1);
      end
      if (p0 && p1) rr_m = e0;
      if (e0) p0 = 0;
      if (e1) p1 = 0;
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    logic r0, r1;
    do_reset();
    step(1, 0, 9'h033, '0, 1, 0, 9'h133, '0, r0, r1);
    step(0, 0, '0, '0, 1, 0, 9'h134, '0, r0, r1);
    checks++;
    if (bus.MEM_CE !== 1'b1) begin
      failures++; $display("FAIL mid_issue ce=%b exp=1", bus.MEM_CE);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (bus.MEM_CE !== 1'b0 || bus.BUSY !== 1'b0) begin
      failures++; $display("FAIL mid_async ce=%b busy=%b exp 0 0", bus.MEM_CE, bus.BUSY);
    end
    exp_q.delete();
    bus.REQ0_VALID = 1'b0;
    bus.REQ1_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    rr_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, '0, 0, 0, '0, '0, r0, r1);
      checks++;
      if (bus.RSP0_VALID !== 1'b0 || bus.RSP1_VALID !== 1'b0) begin
        failures++; $display("FAIL mid_no_rsp i=%0d got=%b%b exp=00", i, bus.RSP0_VALID, bus.RSP1_VALID);
      end
    end
    step(1, 0, 9'h035, '0, 1, 0, 9'h135, '0, r0, r1);
    checks++;
    if ({r0, r1} !== 2'b10) begin
      failures++; $display("FAIL mid_rr_cleared got=%b exp=10", {r0, r1});
    end
    step(0, 0, '0, '0, 1, 0, 9'h135, '0, r0, r1);
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
    rr_m = 1'b0;
    RST = 1'b1;
    bus.REQ0_VALID = 1'b0; bus.REQ0_WE = 1'b0; bus.REQ0_ADDR = '0; bus.REQ0_WDATA = '0;
    bus.REQ1_VALID = 1'b0; bus.REQ1_WE = 1'b0; bus.REQ1_ADDR = '0; bus.REQ1_WDATA = '0;
    #2;
    test_reset();
    test_single_read();
    test_write_busy();
    test_alternate();
    test_port1_only();
    test_raw();
    test_bank_cross();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL drain_pending got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
